// File: rtl/axi_lite_if.sv
// AXI-Lite channel bundle (AW/W/B/AR/R) shared by the arbiter's upstream and downstream sides.
// The master modport is the initiator side; the slave modport is the responder side.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        output ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid,
        input  ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        input  ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid,
        output ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// N-to-1 AXI-Lite arbiter: independent round-robin write and read FSMs, one outstanding
// transaction each, 1-cycle grant latency, responses passed through untouched.
//
// state  | meaning
// W_IDLE | no write granted; arbitrate aw_valid requests from wptr
// W_ADDR | forwarding AW and W of wgrant until both have handshaken
// W_RESP | waiting for the B handshake, then advance wptr past wgrant
// R_IDLE | no read granted; arbitrate ar_valid requests from rptr
// R_ADDR | forwarding AR of rgrant until it handshakes
// R_RESP | waiting for the R handshake, then advance rptr past rgrant
module axi_lite_arbiter #(
    parameter int N          = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_lite_if.slave  s_axi [N-1:0],
    axi_lite_if.master m_axi
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = DATA_WIDTH / 8;

    typedef logic [IW-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rstate_t;

    wstate_t wstate;
    rstate_t rstate;
    idx_t    wptr;
    idx_t    rptr;
    idx_t    wgrant;
    idx_t    rgrant;
    logic    aw_done;
    logic    w_done;

    // Upstream signals gathered into plain arrays so they can be indexed by the grant.
    logic [N-1:0]          s_aw_valid;
    logic [N-1:0]          s_w_valid;
    logic [N-1:0]          s_b_ready;
    logic [N-1:0]          s_ar_valid;
    logic [N-1:0]          s_r_ready;
    logic [ADDR_WIDTH-1:0] s_aw_addr [N];
    logic [DATA_WIDTH-1:0] s_w_data  [N];
    logic [SW-1:0]         s_w_strb  [N];
    logic [ADDR_WIDTH-1:0] s_ar_addr [N];

    logic w_addr_st;
    logic w_resp_st;
    logic r_addr_st;
    logic r_resp_st;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    // Round-robin pick: first requester at or above ptr, wrapping N-1 -> 0.
    function automatic idx_t pick(input logic [N-1:0] req, input idx_t ptr);
        idx_t sel   = ptr;
        logic found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                sel   = idx_t'(c);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic idx_t next_idx(input idx_t g);
        return idx_t'((int'(g) + 1) % N);
    endfunction

    assign w_addr_st = (wstate == W_ADDR);
    assign w_resp_st = (wstate == W_RESP);
    assign r_addr_st = (rstate == R_ADDR);
    assign r_resp_st = (rstate == R_RESP);

    assign m_axi.aw_addr  = s_aw_addr[wgrant];
    assign m_axi.w_data   = s_w_data[wgrant];
    assign m_axi.w_strb   = s_w_strb[wgrant];
    assign m_axi.aw_valid = w_addr_st && s_aw_valid[wgrant] && !aw_done;
    assign m_axi.w_valid  = w_addr_st && s_w_valid[wgrant] && !w_done;
    assign m_axi.b_ready  = w_resp_st && s_b_ready[wgrant];
    assign m_axi.ar_addr  = s_ar_addr[rgrant];
    assign m_axi.ar_valid = r_addr_st && s_ar_valid[rgrant];
    assign m_axi.r_ready  = r_resp_st && s_r_ready[rgrant];

    assign aw_hs = m_axi.aw_valid && m_axi.aw_ready;
    assign w_hs  = m_axi.w_valid && m_axi.w_ready;
    assign b_hs  = m_axi.b_valid && m_axi.b_ready;
    assign ar_hs = m_axi.ar_valid && m_axi.ar_ready;
    assign r_hs  = m_axi.r_valid && m_axi.r_ready;

    for (genvar i = 0; i < N; i++) begin : g_up
        logic w_sel;
        logic r_sel;

        assign w_sel = (wgrant == idx_t'(i));
        assign r_sel = (rgrant == idx_t'(i));

        assign s_aw_valid[i] = s_axi[i].aw_valid;
        assign s_w_valid[i]  = s_axi[i].w_valid;
        assign s_b_ready[i]  = s_axi[i].b_ready;
        assign s_ar_valid[i] = s_axi[i].ar_valid;
        assign s_r_ready[i]  = s_axi[i].r_ready;
        assign s_aw_addr[i]  = s_axi[i].aw_addr;
        assign s_w_data[i]   = s_axi[i].w_data;
        assign s_w_strb[i]   = s_axi[i].w_strb;
        assign s_ar_addr[i]  = s_axi[i].ar_addr;

        assign s_axi[i].aw_ready = w_addr_st && w_sel && m_axi.aw_ready && !aw_done;
        assign s_axi[i].w_ready  = w_addr_st && w_sel && m_axi.w_ready && !w_done;
        assign s_axi[i].b_valid  = w_resp_st && w_sel && m_axi.b_valid;
        assign s_axi[i].b_resp   = (w_resp_st && w_sel) ? m_axi.b_resp : 2'b00;
        assign s_axi[i].ar_ready = r_addr_st && r_sel && m_axi.ar_ready;
        assign s_axi[i].r_valid  = r_resp_st && r_sel && m_axi.r_valid;
        assign s_axi[i].r_data   = (r_resp_st && r_sel) ? m_axi.r_data : '0;
        assign s_axi[i].r_resp   = (r_resp_st && r_sel) ? m_axi.r_resp : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate  <= W_IDLE;
            wptr    <= '0;
            wgrant  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (|s_aw_valid) begin
                        wgrant <= pick(s_aw_valid, wptr);
                        wstate <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    // AW and W may complete in either order or together.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        wstate  <= W_RESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_done || aw_hs;
                        w_done  <= w_done || w_hs;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        wstate <= W_IDLE;
                        wptr   <= next_idx(wgrant);
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= R_IDLE;
            rptr   <= '0;
            rgrant <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (|s_ar_valid) begin
                        rgrant <= pick(s_ar_valid, rptr);
                        rstate <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (ar_hs) begin
                        rstate <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (r_hs) begin
                        rstate <= R_IDLE;
                        rptr   <= next_idx(rgrant);
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with N=2: round-robin writes, split AW/W, parallel
// read/write, response pass-through and reset mid-transaction.
module tb_axi_lite_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if [1:0] ();
    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

    axi_lite_arbiter #(.N(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (s_if),
        .m_axi (m_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if[0].aw_addr = '0; s_if[0].aw_valid = 0; s_if[0].w_data = '0; s_if[0].w_strb = '0;
        s_if[0].w_valid = 0;  s_if[0].b_ready = 0;  s_if[0].ar_addr = '0; s_if[0].ar_valid = 0;
        s_if[0].r_ready = 0;
        s_if[1].aw_addr = '0; s_if[1].aw_valid = 0; s_if[1].w_data = '0; s_if[1].w_strb = '0;
        s_if[1].w_valid = 0;  s_if[1].b_ready = 0;  s_if[1].ar_addr = '0; s_if[1].ar_valid = 0;
        s_if[1].r_ready = 0;
        m_if.aw_ready = 1; m_if.w_ready = 1; m_if.b_resp = 0; m_if.b_valid = 0;
        m_if.ar_ready = 0; m_if.r_data = '0; m_if.r_resp = 0; m_if.r_valid = 0;

        // Both masters request from reset
        s_if[0].aw_addr = 32'h100; s_if[0].w_data = 32'h1111_1111; s_if[0].w_strb = 4'hF;
        s_if[0].aw_valid = 1; s_if[0].w_valid = 1;
        s_if[1].aw_addr = 32'h200; s_if[1].w_data = 32'h2222_2222; s_if[1].w_strb = 4'hF;
        s_if[1].aw_valid = 1; s_if[1].w_valid = 1;
        #2;
        chk("rst_m_aw_valid", m_if.aw_valid, 0);
        chk("rst_m_w_valid", m_if.w_valid, 0);
        chk("rst_m_ar_valid", m_if.ar_valid, 0);
        chk("rst_m_b_ready", m_if.b_ready, 0);
        chk("rst_m_r_ready", m_if.r_ready, 0);
        chk("rst_s0_aw_ready", s_if[0].aw_ready, 0);
        chk("rst_s0_w_ready", s_if[0].w_ready, 0);
        chk("rst_s1_b_valid", s_if[1].b_valid, 0);
        tick();
        tick();
        chk("rst_clk_m_aw_valid", m_if.aw_valid, 0);
        rst_n = 1;
        #1;
        chk("idle_m_aw_valid", m_if.aw_valid, 0);

        // Round 1: master 0
        tick();
        chk("r1_m_aw_valid", m_if.aw_valid, 1);
        chk("r1_m_aw_addr", m_if.aw_addr, 32'h100);
        chk("r1_m_w_data", m_if.w_data, 32'h1111_1111);
        chk("r1_s0_aw_ready", s_if[0].aw_ready, 1);
        chk("r1_s0_w_ready", s_if[0].w_ready, 1);
        chk("r1_s1_aw_ready", s_if[1].aw_ready, 0);
        tick();
        s_if[0].aw_valid = 0; s_if[0].w_valid = 0; s_if[0].b_ready = 1;
        m_if.b_valid = 1; m_if.b_resp = 2'b00;
        #1;
        chk("r1_resp_m_b_ready", m_if.b_ready, 1);
        chk("r1_resp_s0_b_valid", s_if[0].b_valid, 1);
        chk("r1_resp_s1_b_valid", s_if[1].b_valid, 0);
        chk("r1_resp_m_aw_valid", m_if.aw_valid, 0);
        tick();
        m_if.b_valid = 0; s_if[0].b_ready = 0;
        #1;
        chk("r1_idle_m_aw_valid", m_if.aw_valid, 0);
        chk("r1_idle_m_b_ready", m_if.b_ready, 0);

        // Round 2: master 1, slave answers DECERR
        tick();
        chk("r2_m_aw_valid", m_if.aw_valid, 1);
        chk("r2_m_aw_addr", m_if.aw_addr, 32'h200);
        chk("r2_s1_aw_ready", s_if[1].aw_ready, 1);
        chk("r2_s0_aw_ready", s_if[0].aw_ready, 0);
        tick();
        s_if[1].aw_valid = 0; s_if[1].w_valid = 0; s_if[1].b_ready = 1;
        m_if.b_valid = 1; m_if.b_resp = 2'b11;
        #1;
        chk("r2_s1_b_valid", s_if[1].b_valid, 1);
        chk("r2_s1_b_resp", s_if[1].b_resp, 2'b11);
        chk("r2_s0_b_valid", s_if[0].b_valid, 0);
        tick();
        m_if.b_valid = 0; m_if.b_resp = 0; s_if[1].b_ready = 0;
        s_if[0].aw_addr = 32'h300; s_if[0].aw_valid = 1; s_if[0].w_valid = 1;
        s_if[1].aw_addr = 32'h400; s_if[1].w_data = 32'h4444_4444;
        s_if[1].aw_valid = 1; s_if[1].w_valid = 1;

        // Round 3: master 0 again
        tick();
        chk("r3_m_aw_addr", m_if.aw_addr, 32'h300);
        chk("r3_s0_aw_ready", s_if[0].aw_ready, 1);
        tick();
        s_if[0].aw_valid = 0; s_if[0].w_valid = 0; s_if[0].b_ready = 1;
        m_if.b_valid = 1;
        tick();
        m_if.b_valid = 0; s_if[0].b_ready = 0;
        s_if[0].aw_valid = 1; s_if[0].w_valid = 1;
        m_if.aw_ready = 1; m_if.w_ready = 0;

        // Master 1: AW accepted three cycles before W, master 0 kept waiting
        tick();
        chk("split_m_aw_addr", m_if.aw_addr, 32'h400);
        chk("split_m_w_valid", m_if.w_valid, 1);
        chk("split_s1_aw_ready", s_if[1].aw_ready, 1);
        chk("split_s1_w_ready", s_if[1].w_ready, 0);
        chk("split_s0_aw_ready", s_if[0].aw_ready, 0);
        tick();
        chk("split_aw_masked", m_if.aw_valid, 0);
        chk("split_w_still", m_if.w_valid, 1);
        chk("split_s1_aw_ready_done", s_if[1].aw_ready, 0);
        s_if[1].aw_valid = 0;
        tick();
        chk("split_w_wait", m_if.w_valid, 1);
        chk("split_no_b_ready", m_if.b_ready, 0);
        chk("split_s0_w_ready", s_if[0].w_ready, 0);
        tick();
        m_if.w_ready = 1;
        #1;
        chk("split_s1_w_ready", s_if[1].w_ready, 1);
        chk("split_s0_w_ready2", s_if[0].w_ready, 0);
        chk("split_no_b_ready2", m_if.b_ready, 0);
        tick();
        s_if[1].w_valid = 0; s_if[1].b_ready = 1; m_if.b_valid = 1;
        #1;
        chk("split_m_b_ready", m_if.b_ready, 1);
        chk("split_s1_b_valid", s_if[1].b_valid, 1);
        chk("split_s0_b_valid", s_if[0].b_valid, 0);
        tick();
        m_if.b_valid = 0; s_if[1].b_ready = 0;
        m_if.aw_ready = 0; m_if.w_ready = 0;
        s_if[0].aw_addr = 32'h1000; s_if[0].w_data = 32'hA5A5_A5A5;
        s_if[1].ar_addr = 32'h2000; s_if[1].ar_valid = 1;

        // Parallel write (master 0) and read (master 1)
        tick();
        chk("par_m_aw_addr", m_if.aw_addr, 32'h1000);
        chk("par_m_aw_valid", m_if.aw_valid, 1);
        chk("par_m_ar_valid", m_if.ar_valid, 1);
        chk("par_m_ar_addr", m_if.ar_addr, 32'h2000);
        chk("par_s1_ar_ready_lo", s_if[1].ar_ready, 0);
        m_if.aw_ready = 1; m_if.w_ready = 1; m_if.ar_ready = 1;
        #1;
        chk("par_s1_ar_ready", s_if[1].ar_ready, 1);
        chk("par_s0_ar_ready", s_if[0].ar_ready, 0);
        chk("par_s0_aw_ready", s_if[0].aw_ready, 1);
        tick();
        s_if[0].aw_valid = 0; s_if[0].w_valid = 0; s_if[1].ar_valid = 0;
        m_if.ar_ready = 0;
        m_if.r_valid = 1; m_if.r_data = 32'hDEAD_BEEF; m_if.r_resp = 2'b00;
        s_if[1].r_ready = 1; s_if[0].b_ready = 1; m_if.b_valid = 1;
        #1;
        chk("par_s1_r_valid", s_if[1].r_valid, 1);
        chk("par_s0_r_valid", s_if[0].r_valid, 0);
        chk("par_s1_r_data", s_if[1].r_data, 32'hDEAD_BEEF);
        chk("par_m_r_ready", m_if.r_ready, 1);
        chk("par_s0_b_valid", s_if[0].b_valid, 1);
        chk("par_m_ar_valid_resp", m_if.ar_valid, 0);
        tick();
        m_if.r_valid = 0; m_if.b_valid = 0; s_if[1].r_ready = 0; s_if[0].b_ready = 0;
        s_if[1].aw_addr = 32'h500; s_if[1].aw_valid = 1; s_if[1].w_valid = 1;
        #1;
        chk("par_idle_m_r_ready", m_if.r_ready, 0);
        chk("par_idle_s1_r_valid", s_if[1].r_valid, 0);

        // Reset during W_RESP with B pending
        tick();
        chk("rstmid_m_aw_addr", m_if.aw_addr, 32'h500);
        tick();
        s_if[1].aw_valid = 0; s_if[1].w_valid = 0; s_if[1].b_ready = 1; m_if.b_valid = 1;
        #1;
        chk("rstmid_s1_b_valid_pre", s_if[1].b_valid, 1);
        rst_n = 0;
        #1;
        chk("rstmid_s1_b_valid", s_if[1].b_valid, 0);
        chk("rstmid_m_b_ready", m_if.b_ready, 0);
        s_if[0].aw_addr = 32'h600; s_if[0].aw_valid = 1; s_if[0].w_valid = 1;
        s_if[1].aw_addr = 32'h700; s_if[1].aw_valid = 1; s_if[1].w_valid = 1;
        tick();
        chk("rstmid_hold_m_aw_valid", m_if.aw_valid, 0);
        chk("rstmid_hold_s1_aw_ready", s_if[1].aw_ready, 0);
        rst_n = 1;
        m_if.b_valid = 0;
        tick();
        chk("rstmid_regrant_addr", m_if.aw_addr, 32'h600);
        chk("rstmid_regrant_s0_aw_ready", s_if[0].aw_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the number of upstream masters (N >= 1).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the AXI-Lite address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, giving the AXI-Lite data width; strobe width is DATA_WIDTH/8.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port s_axi, axi_lite_if.slave array [N-1:0]: upstream masters, full AW/W/B/AR/R channels.
REQ-007 The block SHALL have port m_axi, axi_lite_if.master, 1 instance: the shared downstream port.

Function
REQ-008 The block SHALL run write arbitration (AW/W/B) and read arbitration (AR/R) independently and concurrently, one FSM each.
REQ-009 The write FSM SHALL have states W_IDLE, W_ADDR and W_RESP; the read FSM SHALL have states R_IDLE, R_ADDR and R_RESP.
REQ-010 Each FSM SHALL have exactly one outstanding transaction at a time.
REQ-011 Write request i SHALL be s_axi[i].aw_valid; W valid is not required to win.
REQ-012 Read request i SHALL be s_axi[i].ar_valid.
REQ-013 In W_IDLE with any request, the write FSM SHALL register wgrant = first requester found searching upward from wptr with wrap (N-1 -> 0) and SHALL move to W_ADDR on the next edge.
REQ-014 In R_IDLE with any request, the read FSM SHALL register rgrant = first requester found searching upward from rptr with wrap (N-1 -> 0) and SHALL move to R_ADDR on the next edge.
REQ-015 Arbitration latency SHALL be 1 cycle: a request seen in IDLE at cycle k SHALL produce the downstream valid at cycle k+1.
REQ-016 In IDLE, m_axi.aw_valid, m_axi.w_valid and m_axi.ar_valid SHALL be 0, and every upstream aw/w/ar_ready SHALL be 0.
REQ-017 In W_ADDR, m_axi.aw_addr, w_data and w_strb SHALL be driven from s_axi[wgrant].
REQ-018 In W_ADDR, m_axi.aw_valid SHALL equal s_axi[wgrant].aw_valid AND !aw_done, and m_axi.w_valid SHALL equal s_axi[wgrant].w_valid AND !w_done.
REQ-019 In W_ADDR, s_axi[wgrant].aw_ready and w_ready SHALL mirror m_axi, masked by the same done flags; non-granted readies SHALL be 0.
REQ-020 aw_done and w_done SHALL set on their respective downstream handshakes, which may occur in either order or in the same cycle.
REQ-021 W_ADDR SHALL move to W_RESP on the edge at which both aw_done and w_done are, or become, set.
REQ-022 The done flags SHALL clear on entry to W_RESP.
REQ-023 In W_RESP, m_axi.b_ready SHALL equal s_axi[wgrant].b_ready, s_axi[wgrant].b_valid/b_resp SHALL mirror m_axi, and all other b_valid SHALL be 0.
REQ-024 m_axi.b_ready SHALL be 0 outside W_RESP.
REQ-025 On the B handshake the write FSM SHALL go to W_IDLE and set wptr = (wgrant+1) mod N.
REQ-026 In R_ADDR, m_axi.ar_addr/ar_valid SHALL come from s_axi[rgrant] and ar_ready SHALL return only to rgrant; on the AR handshake the read FSM SHALL go to R_RESP.
REQ-027 In R_RESP, r_data/r_resp/r_valid SHALL route to rgrant only, r_ready SHALL come from rgrant, and m_axi.r_ready SHALL be 0 outside R_RESP.
REQ-028 On the R handshake the read FSM SHALL go to R_IDLE and set rptr = (rgrant+1) mod N.
REQ-029 Response codes SHALL pass through unchanged; the block SHALL not generate responses itself.
REQ-030 A requester withdrawing valid before its handshake is an upstream protocol violation; the block SHALL hold the grant and need not recover.
REQ-031 With N=1, grants SHALL always be 0 and the pointers SHALL remain 0.

Reset
REQ-032 While rst_n=0, regardless of clock, both FSMs SHALL be in IDLE, wptr=rptr=0, wgrant=rgrant=0, done flags=0, all downstream valid/ready and all upstream ready/valid outputs=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction with no further handshakes, and the FSMs SHALL resume in IDLE after deassertion.

Verification
REQ-034 N=2, both masters assert aw_valid+w_valid from reset -> master 0 wins with m_axi.aw_valid at the cycle after; after its B, master 1 wins; a third round goes to master 0.
REQ-035 Master 1 AW accepted 3 cycles before its W -> m_axi.aw_valid drops after the handshake, W is still forwarded, and B arrives only after both; master 0 sees no readies throughout.
REQ-036 Simultaneous write from master 0 to 0x1000 and read from master 1 to 0x2000 with r_data=0xDEADBEEF -> both proceed in parallel and only master 1 receives r_valid with 0xDEADBEEF.
REQ-037 Downstream returns b_resp=2'b11 -> the granted master receives 2'b11 unchanged.
REQ-038 rst_n pulled low in W_RESP with b_valid pending -> all outputs are 0 immediately, and after release a new request is granted to master 0.
